// File: rtl/cam_init_seq.sv
// Camera register-init sequencer: walks a config ROM and issues SCCB writes, ms delays, retries on NACK.
// Define CAM_INIT_VERIFY_EN to add read-back verification after each ACKed write.
`timescale 1ns/1ps
module cam_init_seq #(
    parameter int CLK_FREQ  = 27000000,
    parameter int ROM_AW    = 8,
    parameter int REG_AW    = 8,
    parameter int DW        = 8,
    parameter int ROM_LAT   = 1,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [ROM_AW-1:0]    rom_addr,
    input  logic [REG_AW+DW-1:0] rom_data,
    input  logic                 sccb_ready,
    output logic                 sccb_start,
    output logic                 sccb_rw,
    output logic [REG_AW-1:0]    sccb_addr,
    output logic [DW-1:0]        sccb_wdata,
    input  logic                 sccb_done,
    input  logic                 sccb_ack,
    input  logic [DW-1:0]        sccb_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ROM_AW-1:0]    err_addr,
    output logic [1:0]           err_code
);

    localparam int PRESCALE = (CLK_FREQ / 1000 < 1) ? 1 : CLK_FREQ / 1000;
    localparam int PW       = $clog2(PRESCALE + 1);
    localparam logic [1:0] FETCH_LAST = 2'(ROM_LAT - 1);
    localparam logic [3:0] RETRY_LIM  = 4'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WR_REQ,
        S_WR_WAIT,
        S_DELAY,
        S_ADVANCE,
        S_DONE,
        S_ERROR
`ifdef CAM_INIT_VERIFY_EN
        ,
        S_VF_REQ,
        S_VF_WAIT
`endif
    } state_t;

    state_t            state, state_d, wr_ok_next;
    logic [1:0]        fetch_cnt;
    logic [REG_AW-1:0] ent_a;
    logic [DW-1:0]     ent_d;
    logic [3:0]        retry_cnt;
    logic [DW-1:0]     ms_cnt;
    logic [PW-1:0]     pre_cnt;

    logic [REG_AW-1:0] rom_a;
    logic [DW-1:0]     rom_d;
    logic              a_ones, d_ones, retry_ok, pre_last;

    assign rom_a    = rom_data[REG_AW+DW-1:DW];
    assign rom_d    = rom_data[DW-1:0];
    assign a_ones   = &rom_a;
    assign d_ones   = &rom_d;
    assign retry_ok = retry_cnt < RETRY_LIM;
    assign pre_last = pre_cnt == PW'(PRESCALE - 1);

    assign sccb_addr  = ent_a;
    assign sccb_wdata = ent_d;

`ifdef CAM_INIT_VERIFY_EN
    // Data with the top bit set marks volatile registers that cannot be read back.
    assign wr_ok_next = ent_d[DW-1] ? S_ADVANCE : S_VF_REQ;
    assign sccb_rw    = (state == S_VF_REQ) || (state == S_VF_WAIT);
`else
    logic unused_rdata;
    assign wr_ok_next   = S_ADVANCE;
    assign sccb_rw      = 1'b0;
    assign unused_rdata = ^sccb_rdata;
`endif

    always_comb begin
        state_d    = state;
        sccb_start = 1'b0;
        case (state)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  if (fetch_cnt == FETCH_LAST) state_d = S_DECODE;
            S_DECODE: begin
                if (a_ones && d_ones)
                    state_d = S_DONE;
                else if (a_ones)
                    state_d = (rom_d == '0) ? S_ADVANCE : S_DELAY;
                else
                    state_d = S_WR_REQ;
            end
            S_WR_REQ: begin
                if (sccb_ready) begin
                    sccb_start = 1'b1;
                    state_d    = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (sccb_done) begin
                    if (sccb_ack)      state_d = wr_ok_next;
                    else if (retry_ok) state_d = S_WR_REQ;
                    else               state_d = S_ERROR;
                end
            end
`ifdef CAM_INIT_VERIFY_EN
            S_VF_REQ: begin
                if (sccb_ready) begin
                    sccb_start = 1'b1;
                    state_d    = S_VF_WAIT;
                end
            end
            S_VF_WAIT: begin
                if (sccb_done) begin
                    if (!sccb_ack)                state_d = retry_ok ? S_VF_REQ : S_ERROR;
                    else if (sccb_rdata == ent_d) state_d = S_ADVANCE;
                    else                          state_d = S_ERROR;
                end
            end
`endif
            S_DELAY:   if (pre_last && ms_cnt == DW'(1)) state_d = S_ADVANCE;
            S_ADVANCE: state_d = (&rom_addr) ? S_DONE : S_FETCH;
            S_DONE:    state_d = S_IDLE;
            S_ERROR:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            fetch_cnt <= '0;
            ent_a     <= '0;
            ent_d     <= '0;
            retry_cnt <= '0;
            ms_cnt    <= '0;
            pre_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_addr  <= '0;
            err_code  <= '0;
        end else begin
            state <= state_d;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_addr  <= '0;
                        err_code  <= '0;
                        rom_addr  <= '0;
                        retry_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_FETCH: fetch_cnt <= (state_d == S_DECODE) ? '0 : fetch_cnt + 2'd1;
                S_DECODE: begin
                    ent_a   <= rom_a;
                    ent_d   <= rom_d;
                    ms_cnt  <= rom_d;
                    pre_cnt <= '0;
                end
                S_WR_WAIT: begin
                    if (sccb_done && !sccb_ack) begin
                        if (retry_ok) retry_cnt <= retry_cnt + 4'd1;
                        else          err_code  <= 2'b01;
                    end
                end
`ifdef CAM_INIT_VERIFY_EN
                S_VF_WAIT: begin
                    if (sccb_done) begin
                        if (!sccb_ack) begin
                            if (retry_ok) retry_cnt <= retry_cnt + 4'd1;
                            else          err_code  <= 2'b01;
                        end else if (sccb_rdata != ent_d) begin
                            err_code <= 2'b10;
                        end
                    end
                end
`endif
                S_DELAY: begin
                    if (pre_last) begin
                        pre_cnt <= '0;
                        ms_cnt  <= ms_cnt - DW'(1);
                    end else begin
                        pre_cnt <= pre_cnt + PW'(1);
                    end
                end
                S_ADVANCE: begin
                    retry_cnt <= '0;
                    if (!(&rom_addr)) rom_addr <= rom_addr + ROM_AW'(1);
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                S_ERROR: begin
                    error    <= 1'b1;
                    busy     <= 1'b0;
                    err_addr <= rom_addr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_init_seq.sv
// Directed bench for cam_init_seq: vector table of ROM images plus hand sequences for delay, reset and verify.
`timescale 1ns/1ps
module tb_cam_init_seq;

    localparam int TB_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_ready, sccb_start, sccb_rw;
    logic [7:0]  sccb_addr, sccb_wdata, sccb_rdata;
    logic        sccb_done, sccb_ack;
    logic        busy, done, error;
    logic [2:0]  err_addr;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    cam_init_seq #(
        .CLK_FREQ (1000000),
        .ROM_AW   (3),
        .REG_AW   (8),
        .DW       (8),
        .ROM_LAT  (TB_LAT),
        .MAX_RETRY(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .sccb_ready(sccb_ready),
        .sccb_start(sccb_start),
        .sccb_rw   (sccb_rw),
        .sccb_addr (sccb_addr),
        .sccb_wdata(sccb_wdata),
        .sccb_done (sccb_done),
        .sccb_ack  (sccb_ack),
        .sccb_rdata(sccb_rdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_addr  (err_addr),
        .err_code  (err_code)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM with TB_LAT cycles of latency
    logic [15:0] mem [8];
    logic [15:0] pipe0, pipe1;
    always @(posedge clk) begin
        pipe0 <= mem[rom_addr];
        pipe1 <= pipe0;
    end
    assign rom_data = pipe1;

    // SCCB master model with a cumulative transaction log
    int          m_lat = 3;
    logic [7:0]  nack_addr = 8'h00;
    int          nack_budget = 0, nack_base = 0, nacks_given = 0;
    logic        force_en = 1'b0;
    logic [7:0]  force_val = 8'h00;
    int          tr_count = 0;
    logic        tr_rw   [512];
    logic [7:0]  tr_addr [512];
    logic [7:0]  tr_data [512];
    int          tr_cyc  [512];
    logic [7:0]  regs    [256];
    logic        m_busy, m_ack;
    logic [7:0]  m_rd;
    int          m_cnt;

    assign sccb_ready = !m_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy     <= 1'b0;
            m_ack      <= 1'b0;
            m_rd       <= 8'h00;
            m_cnt      <= 0;
            sccb_done  <= 1'b0;
            sccb_ack   <= 1'b0;
            sccb_rdata <= 8'h00;
        end else begin
            sccb_done <= 1'b0;
            if (!m_busy && sccb_start) begin
                m_busy            <= 1'b1;
                m_cnt             <= m_lat;
                tr_rw[tr_count]   <= sccb_rw;
                tr_addr[tr_count] <= sccb_addr;
                tr_data[tr_count] <= sccb_wdata;
                tr_cyc[tr_count]  <= cyc;
                tr_count          <= tr_count + 1;
                if (!sccb_rw) begin
                    regs[sccb_addr] <= sccb_wdata;
                    if (sccb_addr == nack_addr && (nacks_given - nack_base) < nack_budget) begin
                        m_ack       <= 1'b0;
                        nacks_given <= nacks_given + 1;
                    end else begin
                        m_ack <= 1'b1;
                    end
                end else begin
                    m_ack <= 1'b1;
                    m_rd  <= force_en ? force_val : regs[sccb_addr];
                end
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy     <= 1'b0;
                    sccb_done  <= 1'b1;
                    sccb_ack   <= m_ack;
                    sccb_rdata <= m_rd;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rom8(input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    task automatic load_rom(input logic [127:0] r);
        for (int k = 0; k < 8; k++) mem[k] = r[k*16 +: 16];
    endtask

    function automatic int count_rw(input int base, input logic rw);
        int n = 0;
        for (int k = base; k < tr_count; k++) if (tr_rw[k] == rw) n++;
        return n;
    endfunction

    function automatic int first_wr(input int base);
        for (int k = base; k < tr_count; k++) if (!tr_rw[k]) return k;
        return -1;
    endfunction

    task automatic pulse_start(output int t0);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done || error) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [127:0] rom;
        logic [7:0]   nack_addr;
        int           nacks;
        int           exp_wr;
        logic         exp_done;
        logic         exp_err;
        logic [1:0]   exp_code;
        logic [2:0]   exp_eaddr;
        logic [2:0]   exp_raddr;
        logic [15:0]  exp_first;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int   base, t0, t_zero, t_delay, fw;
        logic ok;

        rst_n = 1'b0;
        start = 1'b0;
        load_rom(rom8(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {20'h0, busy, done, error, sccb_start, sccb_rw, rom_addr, err_code, err_addr}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        vecs[0] = '{rom8(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
                    8'h00, 0, 2, 1'b1, 1'b0, 2'b00, 3'd0, 3'd2, 16'h1280};
        vecs[1] = '{rom8(16'h0100, 16'h0201, 16'h0302, 16'h0403, 16'h0504, 16'h0605, 16'h0706, 16'h0807),
                    8'h00, 0, 8, 1'b1, 1'b0, 2'b00, 3'd0, 3'd7, 16'h0100};
        vecs[2] = '{rom8(16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h3A04, 16'hFFFF, 16'hFFFF),
                    8'h3A, 3, 9, 1'b1, 1'b0, 2'b00, 3'd0, 3'd6, 16'h1001};
        vecs[3] = '{rom8(16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h3A04, 16'hFFFF, 16'hFFFF),
                    8'h3A, 4, 9, 1'b0, 1'b1, 2'b01, 3'd5, 3'd5, 16'h1001};
        vecs[4] = '{rom8(16'hFF00, 16'h1204, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
                    8'h00, 0, 1, 1'b1, 1'b0, 2'b00, 3'd0, 3'd2, 16'h1204};
        vecs[5] = '{rom8(16'hFFFF, 16'h1111, 16'h2222, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
                    8'h00, 0, 0, 1'b1, 1'b0, 2'b00, 3'd0, 3'd0, 16'h0000};

        for (int i = 0; i < 6; i++) begin
            load_rom(vecs[i].rom);
            nack_addr   = vecs[i].nack_addr;
            nack_budget = vecs[i].nacks;
            nack_base   = nacks_given;
            base        = tr_count;
            pulse_start(t0);
            wait_end(5000, ok);
            check($sformatf("v%0d_finished", i), {31'h0, ok}, 32'h1);
            repeat (20) @(negedge clk);
            check($sformatf("v%0d_done", i),     {31'h0, done},  {31'h0, vecs[i].exp_done});
            check($sformatf("v%0d_error", i),    {31'h0, error}, {31'h0, vecs[i].exp_err});
            check($sformatf("v%0d_busy", i),     {31'h0, busy},  32'h0);
            check($sformatf("v%0d_err_code", i), {30'h0, err_code}, {30'h0, vecs[i].exp_code});
            check($sformatf("v%0d_err_addr", i), {29'h0, err_addr}, {29'h0, vecs[i].exp_eaddr});
            check($sformatf("v%0d_rom_addr", i), {29'h0, rom_addr}, {29'h0, vecs[i].exp_raddr});
            check($sformatf("v%0d_writes", i),   count_rw(base, 1'b0), vecs[i].exp_wr);
            fw = first_wr(base);
            if (fw >= 0)
                check($sformatf("v%0d_first_write", i), {16'h0, tr_addr[fw], tr_data[fw]},
                      {16'h0, vecs[i].exp_first});
        end
        nack_budget = 0;

        // Delay entry timing relative to a zero-length delay entry
        load_rom(rom8(16'hFF00, 16'h1204, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
        base = tr_count;
        pulse_start(t0);
        wait_end(5000, ok);
        check("dly0_finished", {31'h0, ok}, 32'h1);
        t_zero = (tr_count > base) ? tr_cyc[base] - t0 : 999999;
        check("dly0_no_wait", {31'h0, t_zero <= 12}, 32'h1);

        load_rom(rom8(16'hFF0A, 16'h1204, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
        base = tr_count;
        pulse_start(t0);
        wait_end(15000, ok);
        check("dly10_finished", {31'h0, ok}, 32'h1);
        t_delay = (tr_count > base) ? tr_cyc[base] - t0 : 999999;
        check("dly10_cycles", {31'h0, (t_delay - t_zero >= 9997) && (t_delay - t_zero <= 10003)}, 32'h1);
        if (t_delay - t_zero < 9997 || t_delay - t_zero > 10003)
            $display("  delay measured %0d cycles, wanted 10000", t_delay - t_zero);
        check("dly10_write", {16'h0, tr_addr[base], tr_data[base]}, 32'h1204);
        check("dly10_done", {31'h0, done}, 32'h1);

        // Reset in the middle of a write, then restart; a second start while busy is ignored
        load_rom(vecs[0].rom);
        m_lat = 60;
        base  = tr_count;
        pulse_start(t0);
        for (int k = 0; k < 200 && tr_count == base; k++) @(negedge clk);
        check("rst_write_issued", {31'h0, tr_count > base}, 32'h1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {14'h0, busy, done, error, sccb_start, sccb_rw, rom_addr, err_code, err_addr, 3'b0, sccb_wdata}
              & 32'h0003_FFFF | {14'h0, busy, done, error, sccb_start, 14'h0}, 32'h0);
        check("rst_mid_sccb_addr", {24'h0, sccb_addr}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_lat = 3;
        repeat (3) @(negedge clk);
        check("rst_stays_idle", {30'h0, busy, done}, 32'h0);
        base = tr_count;
        pulse_start(t0);
        check("restart_busy", {31'h0, busy}, 32'h1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end(5000, ok);
        check("restart_finished", {31'h0, ok}, 32'h1);
        repeat (20) @(negedge clk);
        check("restart_writes", count_rw(base, 1'b0), 2);
        check("restart_first", {16'h0, tr_addr[base], tr_data[base]}, 32'h1280);
        check("restart_done", {30'h0, done, error}, 32'h2);

`ifdef CAM_INIT_VERIFY_EN
        load_rom(rom8(16'h1204, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
        force_en  = 1'b1;
        force_val = 8'h05;
        base      = tr_count;
        pulse_start(t0);
        wait_end(5000, ok);
        repeat (10) @(negedge clk);
        check("vf_bad_finished", {31'h0, ok}, 32'h1);
        check("vf_bad_error", {31'h0, error}, 32'h1);
        check("vf_bad_code", {30'h0, err_code}, 32'h2);
        check("vf_bad_addr", {29'h0, err_addr}, 32'h0);
        check("vf_bad_reads", count_rw(base, 1'b1), 1);
        force_en = 1'b0;

        load_rom(rom8(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
        base = tr_count;
        pulse_start(t0);
        wait_end(5000, ok);
        repeat (10) @(negedge clk);
        check("vf_skip_done", {30'h0, done, error}, 32'h2);
        check("vf_skip_reads", count_rw(base, 1'b1), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
